// File: rtl/serial_comp_msb_pkg.sv
// Shared definitions for the MSB-first serial magnitude comparator.
package serial_comp_msb_pkg;

    // Width of one scanned digit.
    localparam int DIGIT_W = 2;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_comp_msb_comp2.sv
// comp_2: 2-bit magnitude compare stage with cascade inputs from a less
// significant stage (EQ0/GT0). With EQ0=1, GT0=0 it is a plain 2-bit compare.
module comp_2 (
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       EQ0,
    input  logic       GT0,
    output logic       EQ1,
    output logic       GT1
);

    logic w_eq;
    logic w_gt;

    // Local digit compare, then merge with the lower-order cascade result.
    always_comb begin
        w_eq = (A == B);
        w_gt = (A > B);
        EQ1  = w_eq & EQ0;
        GT1  = w_gt | (w_eq & GT0);
    end

endmodule

// File: rtl/serial_comp_msb.sv
// MSB-first serial magnitude comparator: one comp_2 reused over time, one
// 2-bit digit per clock, stopping at the first unequal digit.
module serial_comp_msb
    import serial_comp_msb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [WIDTH-1:0]            A,
    input  logic [WIDTH-1:0]            B,
    output logic                        busy,
    output logic                        done,
    output logic                        EQ,
    output logic                        GT,
    output logic                        LT,
    output logic [$clog2(WIDTH/2):0]    cycles
);

    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW   = $clog2(NDIG) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [KW-1:0]     r_k;
    logic [CW-1:0]     r_cycles;
    logic              r_eq;
    logic              r_gt;
    logic              r_lt;

    logic              w_dig_eq;
    logic              w_dig_gt;
    logic              w_last;
    logic              w_accept;

    // Single shared digit compare on the top digits of the shift registers.
    comp_2 u_comp (
        .A   (r_a[WIDTH-1 -: DIGIT_W]),
        .B   (r_b[WIDTH-1 -: DIGIT_W]),
        .EQ0 (1'b1),
        .GT0 (1'b0),
        .EQ1 (w_dig_eq),
        .GT1 (w_dig_gt)
    );

    assign w_last   = (r_k == K_LAST);
    assign w_accept = (r_state != SCAN) && start;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: a start in IDLE or DONE enters SCAN with no bubble; SCAN
    // ends on the first unequal digit or after the last digit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SCAN;
            SCAN:    if (!w_dig_eq || w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? SCAN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, digit shifting, counters and result flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_cycles <= '0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
        end else if (w_accept) begin
            r_a      <= A;
            r_b      <= B;
            r_k      <= '0;
            r_cycles <= '0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
        end else if (r_state == SCAN) begin
            r_cycles <= r_cycles + CW'(1);
            if (!w_dig_eq) begin
                r_gt <= w_dig_gt;
                r_lt <= !w_dig_gt;
            end else if (w_last) begin
                r_eq <= 1'b1;
            end else begin
                r_a <= r_a << DIGIT_W;
                r_b <= r_b << DIGIT_W;
                r_k <= r_k + KW'(1);
            end
        end
    end

    // Outputs are flop values or decodes of the state flop only.
    assign busy   = (r_state == SCAN);
    assign done   = (r_state == DONE);
    assign EQ     = r_eq;
    assign GT     = r_gt;
    assign LT     = r_lt;
    assign cycles = r_cycles;

endmodule

// File: tb/tb_serial_comp_msb.sv
// Scoreboard bench for serial_comp_msb at WIDTH=16 and WIDTH=2.
module tb_serial_comp_msb;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // WIDTH=16 instance
    logic        start;
    logic [15:0] A, B;
    logic        busy, done, EQ, GT, LT;
    logic [3:0]  cycles;

    // WIDTH=2 instance
    logic        start2;
    logic [1:0]  A2, B2;
    logic        busy2, done2, EQ2, GT2, LT2;
    logic [0:0]  cycles2;

    int total = 0;
    int bad   = 0;

    // expected {EQ,GT,LT,cycles}
    logic [6:0] q16[$];
    logic [3:0] q2[$];

    always #5 clock = ~clock;

    serial_comp_msb #(.WIDTH(16)) dut (
        .clock(clock), .reset(reset), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .EQ(EQ), .GT(GT), .LT(LT), .cycles(cycles)
    );

    serial_comp_msb #(.WIDTH(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .A(A2), .B(B2),
        .busy(busy2), .done(done2), .EQ(EQ2), .GT(GT2), .LT(LT2), .cycles(cycles2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare on every done pulse.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (q16.size() == 0) check("w16_unexpected_done", 1, 0);
            else check("w16_result", {EQ, GT, LT, cycles}, q16.pop_front());
        end
    end

    always @(negedge clock) begin
        if (!reset && done2) begin
            if (q2.size() == 0) check("w2_unexpected_done", 1, 0);
            else check("w2_result", {EQ2, GT2, LT2, cycles2}, q2.pop_front());
        end
    end

    task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                           input bit push, input logic [6:0] exp);
        if (push) q16.push_back(exp);
        A = a; B = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Counts busy cycles until done; bounded.
    task automatic wait_done16(output int nb);
        bit got = 0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin got = 1; break; end
            if (busy) nb++;
        end
        if (!got) check("w16_timeout", 0, 1);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b);
        bit got = 0;
        q2.push_back({a == b, a > b, a < b, 1'b1});
        A2 = a; B2 = b; start2 = 1'b1;
        @(posedge clock); #1;
        start2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done2) begin got = 1; break; end
        end
        if (!got) check("w2_timeout", 0, 1);
    endtask

    int nb;

    initial begin
        start = 0; A = 0; B = 0;
        start2 = 0; A2 = 0; B2 = 0;
        #12;
        check("rst_w16_outs", {busy, done, EQ, GT, LT, cycles}, 0);
        check("rst_w2_outs", {busy2, done2, EQ2, GT2, LT2, cycles2}, 0);
        @(posedge clock); #1 reset = 1'b0;

        // MSB digit differs
        issue16(16'h8000, 16'h7FFF, 1, 7'b010_0001);
        wait_done16(nb);
        check("gt_msb_busy_cycles", nb, 1);

        // equal operands, full scan
        issue16(16'hA5A5, 16'hA5A5, 1, 7'b100_1000);
        wait_done16(nb);
        check("eq_busy_cycles", nb, 8);

        // first difference at digit 6
        issue16(16'h1234, 16'h1238, 1, 7'b001_0111);
        wait_done16(nb);
        check("lt_d6_busy_cycles", nb, 7);

        // back-to-back: second pair held during scan, accepted in DONE
        q16.push_back(7'b010_1000);
        q16.push_back(7'b001_0001);
        A = 16'h0001; B = 16'h0000; start = 1'b1;
        @(posedge clock); #1;
        A = 16'h0000; B = 16'hFFFF;
        wait_done16(nb);
        check("b2b_first_busy", nb, 8);
        @(posedge clock); #1;
        start = 1'b0;
        check("b2b_no_bubble_busy", busy, 1);
        wait_done16(nb);
        check("b2b_second_busy", nb, 1);

        // async reset mid-scan
        issue16(16'hA5A5, 16'hA5A5, 0, 7'b0);
        repeat (3) @(posedge clock);
        #1;
        check("mid_scan_cycles", cycles, 3);
        reset = 1'b1;
        #1;
        check("async_rst_outs", {busy, done, EQ, GT, LT, cycles}, 0);
        check("async_rst_state", dut.r_state, 2'd0);
        @(posedge clock); #1 reset = 1'b0;
        issue16(16'h0000, 16'h0000, 1, 7'b100_1000);
        wait_done16(nb);
        check("post_rst_busy", nb, 8);

        // WIDTH=2 exhaustive
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                run2(2'(a), 2'(b));

        repeat (3) @(negedge clock);
        check("w16_queue_empty", q16.size(), 0);
        check("w2_queue_empty", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
